// File: rtl/spram_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spram_pkg : shared types and constants for spram_arbiter          |
// | Revision  : 1.0                                                   |
// +------------------------------------------------------------------+
package spram_pkg;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_A = 2'd1,
    ST_GRANT_B = 2'd2
  } arb_state_e;

  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 4;

  // Out-of-range latencies are pulled to the nearest legal value.
  function automatic int clamp_latency(input int lat);
    if (lat < RD_LATENCY_MIN) return RD_LATENCY_MIN;
    if (lat > RD_LATENCY_MAX) return RD_LATENCY_MAX;
    return lat;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spram_rd_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spram_rd_pipe : RD_LATENCY-deep {valid, owner} read-return pipe   |
// | Revision      : 1.0                                               |
// +------------------------------------------------------------------+
import spram_pkg::*;

module spram_rd_pipe #(
  parameter int RD_LATENCY = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    valid_i,
  input  req_id_e owner_i,
  output logic    valid_o,
  output req_id_e owner_o
);

  localparam int DEPTH = clamp_latency(RD_LATENCY);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] owner_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      owner_q <= '0;
    end else begin
      valid_q[0] <= valid_i;
      owner_q[0] <= owner_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        owner_q[i] <= owner_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign owner_o = req_id_e'(owner_q[DEPTH-1]);

endmodule
`default_nettype wire

// File: rtl/spram_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spram_arbiter : two-requester arbiter in front of a single-port   |
// | RAM. Define SPRAM_ARBITER_RR_EN for round-robin, else A-priority. |
// | Revision      : 1.0                                               |
// +------------------------------------------------------------------+
import spram_pkg::*;

module spram_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  a_gnt,
  output logic                  b_gnt,
  output logic                  a_rvalid,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  arb_state_e            arb_state;
  logic                  prio_b;
  logic                  granted;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  pipe_valid;
  req_id_e               pipe_owner;
  req_id_e               gnt_owner;

`ifdef SPRAM_ARBITER_RR_EN
  logic    conflict;
  req_id_e ptr_q, ptr_d;

  assign conflict = a_req & b_req;
  assign prio_b   = (ptr_q == REQ_B);

  // Pointer names the requester that wins the next conflict.
  always_comb begin
    ptr_d = ptr_q;
    if (rst && conflict) begin
      ptr_d = (arb_state == ST_GRANT_A) ? REQ_B : REQ_A;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) ptr_q <= REQ_A;
    else      ptr_q <= ptr_d;
  end
`else
  assign prio_b = 1'b0;
`endif

  // Grant decision is made and consumed within one cycle.
  always_comb begin
    arb_state = ST_IDLE;
    if (rst) begin
      if (a_req && (!b_req || !prio_b)) arb_state = ST_GRANT_A;
      else if (b_req)                   arb_state = ST_GRANT_B;
    end
  end

  assign a_gnt   = (arb_state == ST_GRANT_A);
  assign b_gnt   = (arb_state == ST_GRANT_B);
  assign granted = a_gnt | b_gnt;

  always_comb begin
    sel_we    = a_we;
    sel_addr  = a_addr;
    sel_wdata = a_wdata;
    if (arb_state == ST_GRANT_B) begin
      sel_we    = b_we;
      sel_addr  = b_addr;
      sel_wdata = b_wdata;
    end
  end

  assign addr_d  = granted ? sel_addr  : addr_q;
  assign wdata_d = granted ? sel_wdata : wdata_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign ram_we    = granted & sel_we;
  assign ram_addr  = rst ? addr_d  : '0;
  assign ram_wdata = rst ? wdata_d : '0;

  assign gnt_owner = b_gnt ? REQ_B : REQ_A;

  spram_rd_pipe #(
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk     (clk),
    .rst     (rst),
    .valid_i (granted & ~sel_we),
    .owner_i (gnt_owner),
    .valid_o (pipe_valid),
    .owner_o (pipe_owner)
  );

  // Outputs are forced low while reset is asserted, before the pipe clears.
  assign a_rvalid = rst & pipe_valid & (pipe_owner == REQ_A);
  assign b_rvalid = rst & pipe_valid & (pipe_owner == REQ_B);
  assign rdata    = rst ? ram_rdata : '0;

endmodule
`default_nettype wire

// File: doc/spram_arbiter.md
SPRAM_ARBITER -- requirements
Module: spram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, RAM address width in bits.
REQ-002 Parameter DATA_WIDTH, default 32, RAM data width in bits.
REQ-003 Parameter RD_LATENCY, default 1, RAM read latency in cycles; legal range 1..4.
REQ-004 Ports:
- clk  in  1  sole clock; all logic is rising-edge.
- rst  in  1  reset, synchronous, active-low.
- a_req / b_req  in  1  each  requester A/B access request.
- a_we / b_we  in  1  each  1 = write, 0 = read.
- a_addr / b_addr  in  ADDR_WIDTH each  access address.
- a_wdata / b_wdata  in  DATA_WIDTH each  write data.
- a_gnt / b_gnt  out  1  each  request accepted this cycle.
- a_rvalid / b_rvalid  out  1  each  read data valid for that requester.
- rdata  out  DATA_WIDTH  read data; shared by A and B, qualified by a_rvalid/b_rvalid.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_rdata  in  DATA_WIDTH  RAM read data, RD_LATENCY cycles after the address.

Function
REQ-005 The block SHALL issue at most one RAM access per cycle and SHALL drive ram_we/ram_addr/ram_wdata combinationally from the granted requester's inputs.
REQ-006 A request SHALL be held with stable we/addr/wdata until its gnt; the access SHALL be complete in the gnt cycle.
REQ-007 With only one requester asserting, that requester SHALL be granted in the same cycle.
REQ-008 Simultaneous requests SHALL be resolved by the arbitration policy (REQ-016/017); exactly one gnt SHALL assert.
REQ-009 With no grant, ram_we SHALL be 0 and ram_addr/ram_wdata SHALL hold their last value.
REQ-010 A granted read SHALL assert that requester's rvalid exactly RD_LATENCY cycles after gnt, with rdata = ram_rdata, via a RD_LATENCY-deep {valid, owner} shift pipeline.
REQ-011 a_rvalid and b_rvalid SHALL never be high together; back-to-back reads SHALL yield back-to-back rvalids in grant order.
REQ-012 A granted write SHALL produce no rvalid.
REQ-013 Same-address read and write granted in consecutive cycles SHALL resolve in grant order; no forwarding.
REQ-014 Grant state machine: IDLE (no request) -> GRANT_A or GRANT_B per cycle per policy; every state is one cycle, with no lock or burst hold.

Reset
REQ-015 While rst=0: a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we = 0; ram_addr, ram_wdata, rdata = 0; the read pipeline cleared; the priority pointer = A. Reads in flight at reset SHALL be dropped and produce no rvalid after reset release.

Configuration
REQ-016 With macro SPRAM_ARBITER_RR_EN defined: round-robin; on conflict the requester not granted last SHALL win; the pointer updates only on a conflict grant.
REQ-017 Without SPRAM_ARBITER_RR_EN: fixed priority; A always wins conflicts; no pointer register exists.

Structure
REQ-018 A shared package spram_pkg SHALL hold the requester-ID enum (REQ_A, REQ_B), the arbiter state enum, and the RD_LATENCY legal-range constants.
REQ-019 The read-return pipeline SHALL be sub-module spram_rd_pipe (parameter RD_LATENCY; ports: in valid/owner, out valid/owner).
REQ-020 The RAM itself SHALL be external and not instantiated inside spram_arbiter.

Verification
REQ-021 Reset: hold rst=0 with a_req=b_req=1 -> all gnt/rvalid/ram_we = 0; release -> A granted first.
REQ-022 Single read: A reads addr 0x10 (RAM holds 0xDEADBEEF), RD_LATENCY=1 -> a_gnt in cycle 0, a_rvalid with rdata=0xDEADBEEF in cycle 1, b_rvalid=0.
REQ-023 Conflict, RR: A and B both request continuously for 6 cycles -> grants A,B,A,B,A,B; fixed priority: A on all 6 cycles, b_gnt=0.
REQ-024 Write then read: B writes 0x55 to addr 3, then A reads addr 3 -> A gets rdata=0x55; no rvalid for the write.
REQ-025 Latency: RD_LATENCY=3, A then B reads on consecutive cycles -> a_rvalid at cycle 3, b_rvalid at cycle 4, with the correct data for each.
REQ-026 Reset mid-read: assert rst one cycle after a read grant with RD_LATENCY=2 -> no rvalid after reset release.
